multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 Port reset, input, 1, synchronous active-high reset.
REQ-003 Port opcode, input, 4, instruction opcode from the instruction register; stable from DECODE until instruction retires.
REQ-004 Port zero, input, 1, ALU zero flag.
REQ-005 Port mem_ready, input, 1, memory completes the current access this cycle.
REQ-006 Port mem_req / mem_write / iord, output, 1 each:
- memory access request;
- write strobe;
- address select (0=PC, 1=ALUOut).
REQ-007 Port ir_write, output, 1, load instruction register.
REQ-008 Port pc_en, output, 1, PC load enable.
REQ-009 Port pc_source, output, 2, PC mux select (00=ALU result, 01=ALUOut, 10=jump target).
REQ-010 Port alu_src_a, output, 1, ALU A select (0=PC, 1=reg A).
REQ-011 Port alu_src_b, output, 2, ALU B select (00=reg B, 01=constant 1, 10=immediate).
REQ-012 Port alu_control, output, 3, ALU op: 010 add, 110 sub, 000 and.
REQ-013 Port reg_write / mem_to_reg, output, 1 each:
- register file write enable;
- writeback select (1=ALUOut, 0=memory data).
REQ-014 Port retire / illegal, output, 1 each, one-cycle pulses: instruction completed / undefined opcode.
REQ-015 Port state, output, 4, current FSM state for debug.

Function
REQ-016 Moore FSM, state encoding fixed:
- FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEMADDR=4, MEMREAD=5;
- MEMWB=6, MEMWRITE=7, ALUWB=8, BRANCH=9, JUMP=10.
- Codes 11-15 unused; any unused code returns to FETCH next cycle with all outputs 0.
REQ-017 Outputs not listed for a state are 0; alu_control defaults to 010.
REQ-018 FETCH outputs:
- mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, pc_source=00.
- ir_write=pc_en=mem_ready.
- Holds in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
REQ-019 DECODE: alu_src_a=0, alu_src_b=10 (target precompute into ALUOut); next state by opcode:
- 0000, 0010, 0011 -> EXEC_R;
- 0001 -> EXEC_I;
- 0100, 0101 -> MEMADDR;
- 0110 -> BRANCH;
- 0111 -> JUMP;
- 1xxx -> FETCH with illegal=1 and retire=1.
REQ-020 EXEC_R: alu_src_a=1, alu_src_b=00; alu_control = 010 (0000), 110 (0010), 000 (0011); next ALUWB.
REQ-021 EXEC_I: alu_src_a=1, alu_src_b=10, alu_control=010; next ALUWB.
REQ-022 ALUWB: reg_write=1, mem_to_reg=1, retire=1; next FETCH.
REQ-023 MEMADDR: alu_src_a=1, alu_src_b=10, alu_control=010; next MEMREAD (0100) or MEMWRITE (0101).
REQ-024 MEMREAD: mem_req=1, iord=1; holds until mem_ready=1, then MEMWB.
REQ-025 MEMWB: reg_write=1, mem_to_reg=0, retire=1; next FETCH.
REQ-026 MEMWRITE: mem_req=1, iord=1, mem_write=1; holds until mem_ready=1; retire=mem_ready; then FETCH.
REQ-027 BRANCH (bne):
- alu_src_a=1, alu_src_b=00, alu_control=110, pc_source=01.
- pc_en = ~zero; retire=1; next FETCH.
REQ-028 JUMP: pc_source=10, pc_en=1, retire=1; next FETCH.
REQ-029 Zero-wait latency: R/I-type 4 cycles, lw 5, sw 4, bne 3, j 3, illegal 2; each mem_ready=0 cycle adds one.
REQ-030 mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
REQ-031 mem_write is never asserted without mem_req; reg_write and mem_write are never asserted together.

Reset
REQ-032 reset=1 at a rising edge sets state=FETCH, regardless of current state or pending memory access.
REQ-033 While reset=1, all outputs are 0; this overrides REQ-018.
REQ-034 Reset asserted mid-instruction, including during a stalled MEMWRITE, aborts it: no retire, no reg_write, and no mem_write from the cycle reset is sampled.
REQ-035 First cycle after reset deasserts: state=FETCH with FETCH outputs.

Verification
REQ-036 Reset, then add (0000) with mem_ready=1 always:
- states 0,1,2,8,0;
- alu_control=010 in EXEC_R;
- reg_write=1 only in cycle 4;
- retire=1 in cycle 4.
REQ-037 lw (0100) with mem_ready low 2 cycles in FETCH and 3 in MEMREAD:
- 10 cycles total;
- ir_write=1 exactly once;
- reg_write with mem_to_reg=0 in the last cycle.
REQ-038 bne (0110):
- zero=0 -> pc_en=1 and pc_source=01 in BRANCH;
- zero=1 -> pc_en=0 in BRANCH;
- both cases return to FETCH after 3 cycles.
REQ-039 Opcodes 1000 and 1111: illegal=1 and retire=1 in DECODE, back to FETCH, reg_write and mem_write never asserted.
REQ-040 sw (0101) with mem_ready=0 held, reset pulsed in MEMWRITE: next cycle state=0 with all outputs 0; mem_write drops the same cycle; no retire.
REQ-041 Random opcode and mem_ready stream:
- REQ-031 invariants hold every cycle;
- retire count equals decoded instruction count.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: Moore FSM sequencing fetch, decode,
// execute, memory and writeback for a small 4-bit-opcode ISA.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEMADDR  = 4'd4,
        MEMREAD  = 4'd5,
        MEMWB    = 4'd6,
        MEMWRITE = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;

    state_t st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= FETCH;
        end else begin
            case (st)
                FETCH:    if (mem_ready) st <= DECODE;
                DECODE: begin
                    case (opcode)
                        4'b0000, 4'b0010, 4'b0011: st <= EXEC_R;
                        4'b0001:                   st <= EXEC_I;
                        4'b0100, 4'b0101:          st <= MEMADDR;
                        4'b0110:                   st <= BRANCH;
                        4'b0111:                   st <= JUMP;
                        default:                   st <= FETCH;
                    endcase
                end
                EXEC_R:   st <= ALUWB;
                EXEC_I:   st <= ALUWB;
                MEMADDR:  st <= opcode[0] ? MEMWRITE : MEMREAD;
                MEMREAD:  if (mem_ready) st <= MEMWB;
                MEMWRITE: if (mem_ready) st <= FETCH;
                default:  st <= FETCH;
            endcase
        end
    end

    // Outputs decode from the current state; reset forces everything low.
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        pc_source   = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        if (!reset) begin
            case (st)
                FETCH: begin
                    alu_control = ALU_ADD;
                    mem_req     = 1'b1;
                    alu_src_b   = 2'b01;
                    ir_write    = mem_ready;
                    pc_en       = mem_ready;
                end
                DECODE: begin
                    alu_control = ALU_ADD;
                    alu_src_b   = 2'b10;
                    illegal     = opcode[3];
                    retire      = opcode[3];
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    case (opcode)
                        4'b0010: alu_control = ALU_SUB;
                        4'b0011: alu_control = ALU_AND;
                        default: alu_control = ALU_ADD;
                    endcase
                end
                EXEC_I, MEMADDR: begin
                    alu_control = ALU_ADD;
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                end
                ALUWB: begin
                    alu_control = ALU_ADD;
                    reg_write   = 1'b1;
                    mem_to_reg  = 1'b1;
                    retire      = 1'b1;
                end
                MEMREAD: begin
                    alu_control = ALU_ADD;
                    mem_req     = 1'b1;
                    iord        = 1'b1;
                end
                MEMWB: begin
                    alu_control = ALU_ADD;
                    reg_write   = 1'b1;
                    retire      = 1'b1;
                end
                MEMWRITE: begin
                    alu_control = ALU_ADD;
                    mem_req     = 1'b1;
                    iord        = 1'b1;
                    mem_write   = 1'b1;
                    retire      = mem_ready;
                end
                BRANCH: begin
                    alu_control = ALU_SUB;
                    alu_src_a   = 1'b1;
                    pc_source   = 2'b01;
                    pc_en       = ~zero;
                    retire      = 1'b1;
                end
                JUMP: begin
                    alu_control = ALU_ADD;
                    pc_source   = 2'b10;
                    pc_en       = 1'b1;
                    retire      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = reset ? 4'd0 : st;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector table plus random stream for multicycle_control.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_source, alu_src_b;
    logic       alu_src_a;
    logic [2:0] alu_control;
    logic       reg_write, mem_to_reg, retire, illegal;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
        .pc_source(pc_source), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .retire(retire), .illegal(illegal), .state(state)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic        z;
        logic        mr;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [20:0] e(
        input logic [3:0] st, input logic mreq, input logic mw,
        input logic io, input logic irw, input logic pce,
        input logic [1:0] pcs, input logic asa, input logic [1:0] asb,
        input logic [2:0] aluc, input logic rw, input logic m2r,
        input logic ret, input logic ill);
        return {mreq, mw, io, irw, pce, pcs, asa, asb, aluc,
                rw, m2r, ret, ill, st};
    endfunction

    function automatic vec_t v(input logic rst, input logic [3:0] op,
                               input logic z, input logic mr,
                               input logic [20:0] ex);
        vec_t r;
        r.rst = rst; r.op = op; r.z = z; r.mr = mr; r.exp = ex;
        return r;
    endfunction

    function automatic logic [20:0] outs();
        return {mem_req, mem_write, iord, ir_write, pc_en, pc_source,
                alu_src_a, alu_src_b, alu_control, reg_write,
                mem_to_reg, retire, illegal, state};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [20:0] ZR, F1, F0, DEC, DILL, XADD, XSUB, XAND, XI, AWB;
    logic [20:0] MA, MRD, MWB, MW0, MW1, BR1, BR0, JP;

    int n_dec, n_ret, guard;

    initial begin
        ZR   = '0;
        F1   = e(0, 1,0,0,1,1, 2'b00, 0, 2'b01, 3'b010, 0,0,0,0);
        F0   = e(0, 1,0,0,0,0, 2'b00, 0, 2'b01, 3'b010, 0,0,0,0);
        DEC  = e(1, 0,0,0,0,0, 2'b00, 0, 2'b10, 3'b010, 0,0,0,0);
        DILL = e(1, 0,0,0,0,0, 2'b00, 0, 2'b10, 3'b010, 0,0,1,1);
        XADD = e(2, 0,0,0,0,0, 2'b00, 1, 2'b00, 3'b010, 0,0,0,0);
        XSUB = e(2, 0,0,0,0,0, 2'b00, 1, 2'b00, 3'b110, 0,0,0,0);
        XAND = e(2, 0,0,0,0,0, 2'b00, 1, 2'b00, 3'b000, 0,0,0,0);
        XI   = e(3, 0,0,0,0,0, 2'b00, 1, 2'b10, 3'b010, 0,0,0,0);
        AWB  = e(8, 0,0,0,0,0, 2'b00, 0, 2'b00, 3'b010, 1,1,1,0);
        MA   = e(4, 0,0,0,0,0, 2'b00, 1, 2'b10, 3'b010, 0,0,0,0);
        MRD  = e(5, 1,0,1,0,0, 2'b00, 0, 2'b00, 3'b010, 0,0,0,0);
        MWB  = e(6, 0,0,0,0,0, 2'b00, 0, 2'b00, 3'b010, 1,0,1,0);
        MW0  = e(7, 1,1,1,0,0, 2'b00, 0, 2'b00, 3'b010, 0,0,0,0);
        MW1  = e(7, 1,1,1,0,0, 2'b00, 0, 2'b00, 3'b010, 0,0,1,0);
        BR1  = e(9, 0,0,0,0,1, 2'b01, 1, 2'b00, 3'b110, 0,0,1,0);
        BR0  = e(9, 0,0,0,0,0, 2'b01, 1, 2'b00, 3'b110, 0,0,1,0);
        JP   = e(10,0,0,0,0,1, 2'b10, 0, 2'b00, 3'b010, 0,0,1,0);

        tbl.push_back(v(1, 4'h0, 0, 1, ZR));
        // add
        tbl.push_back(v(0, 4'h0, 0, 1, F1));
        tbl.push_back(v(0, 4'h0, 0, 1, DEC));
        tbl.push_back(v(0, 4'h0, 0, 1, XADD));
        tbl.push_back(v(0, 4'h0, 0, 1, AWB));
        // sub, mem_ready low where it must be ignored
        tbl.push_back(v(0, 4'h2, 0, 1, F1));
        tbl.push_back(v(0, 4'h2, 0, 0, DEC));
        tbl.push_back(v(0, 4'h2, 0, 0, XSUB));
        tbl.push_back(v(0, 4'h2, 0, 0, AWB));
        // and
        tbl.push_back(v(0, 4'h3, 0, 1, F1));
        tbl.push_back(v(0, 4'h3, 0, 1, DEC));
        tbl.push_back(v(0, 4'h3, 0, 1, XAND));
        tbl.push_back(v(0, 4'h3, 0, 1, AWB));
        // addi
        tbl.push_back(v(0, 4'h1, 0, 1, F1));
        tbl.push_back(v(0, 4'h1, 0, 1, DEC));
        tbl.push_back(v(0, 4'h1, 0, 1, XI));
        tbl.push_back(v(0, 4'h1, 0, 1, AWB));
        // lw: 2 fetch stalls, 3 read stalls, 10 cycles
        tbl.push_back(v(0, 4'h4, 0, 0, F0));
        tbl.push_back(v(0, 4'h4, 0, 0, F0));
        tbl.push_back(v(0, 4'h4, 0, 1, F1));
        tbl.push_back(v(0, 4'h4, 0, 0, DEC));
        tbl.push_back(v(0, 4'h4, 0, 1, MA));
        tbl.push_back(v(0, 4'h4, 0, 0, MRD));
        tbl.push_back(v(0, 4'h4, 0, 0, MRD));
        tbl.push_back(v(0, 4'h4, 0, 0, MRD));
        tbl.push_back(v(0, 4'h4, 0, 1, MRD));
        tbl.push_back(v(0, 4'h4, 0, 0, MWB));
        // sw zero wait
        tbl.push_back(v(0, 4'h5, 0, 1, F1));
        tbl.push_back(v(0, 4'h5, 0, 1, DEC));
        tbl.push_back(v(0, 4'h5, 0, 1, MA));
        tbl.push_back(v(0, 4'h5, 0, 1, MW1));
        // bne taken / not taken
        tbl.push_back(v(0, 4'h6, 0, 1, F1));
        tbl.push_back(v(0, 4'h6, 0, 1, DEC));
        tbl.push_back(v(0, 4'h6, 0, 1, BR1));
        tbl.push_back(v(0, 4'h6, 1, 1, F1));
        tbl.push_back(v(0, 4'h6, 1, 1, DEC));
        tbl.push_back(v(0, 4'h6, 1, 1, BR0));
        // j
        tbl.push_back(v(0, 4'h7, 0, 1, F1));
        tbl.push_back(v(0, 4'h7, 0, 1, DEC));
        tbl.push_back(v(0, 4'h7, 0, 1, JP));
        // illegal opcodes
        tbl.push_back(v(0, 4'h8, 0, 1, F1));
        tbl.push_back(v(0, 4'h8, 0, 1, DILL));
        tbl.push_back(v(0, 4'hF, 0, 1, F1));
        tbl.push_back(v(0, 4'hF, 0, 1, DILL));
        // reset during ALUWB aborts the writeback
        tbl.push_back(v(0, 4'h0, 0, 1, F1));
        tbl.push_back(v(0, 4'h0, 0, 1, DEC));
        tbl.push_back(v(0, 4'h0, 0, 1, XADD));
        tbl.push_back(v(1, 4'h0, 0, 1, ZR));
        tbl.push_back(v(0, 4'h0, 0, 0, F0));
        // sw stalled in MEMWRITE, then reset
        tbl.push_back(v(0, 4'h5, 0, 1, F1));
        tbl.push_back(v(0, 4'h5, 0, 0, DEC));
        tbl.push_back(v(0, 4'h5, 0, 0, MA));
        tbl.push_back(v(0, 4'h5, 0, 0, MW0));
        tbl.push_back(v(0, 4'h5, 0, 0, MW0));
        tbl.push_back(v(1, 4'h5, 0, 0, ZR));
        tbl.push_back(v(1, 4'h5, 0, 0, ZR));
        tbl.push_back(v(0, 4'h5, 0, 0, F0));
        tbl.push_back(v(0, 4'h5, 0, 1, F1));

        foreach (tbl[i]) begin
            @(negedge clk);
            reset     = tbl[i].rst;
            opcode    = tbl[i].op;
            zero      = tbl[i].z;
            mem_ready = tbl[i].mr;
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // random stream from DECODE of the last vector onward
        n_dec = 0;
        n_ret = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (state == 4'd0) opcode = 4'($urandom_range(0, 15));
            mem_ready = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            #1;
            if (state == 4'd1) n_dec++;
            if (retire) n_ret++;
            chk("inv_wr_req", 32'(mem_write & ~mem_req), 32'd0);
            chk("inv_rw_mw", 32'(mem_write & reg_write), 32'd0);
            chk("inv_state", 32'(state > 4'd10), 32'd0);
        end
        guard = 0;
        mem_ready = 1'b1;
        do begin
            @(negedge clk);
            #1;
            if (state == 4'd1) n_dec++;
            if (retire) n_ret++;
            guard++;
        end while (state != 4'd0 && guard < 20);
        chk("drain_timeout", 32'(guard >= 20), 32'd0);
        chk("retire_count", 32'(n_ret), 32'(n_dec));
        chk("decode_seen", 32'(n_dec > 50), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
